// File: rtl/gpio_mem_arbiter.sv
// gpio_mem_arbiter: shares the single-port gpiomem between two masters.
// Each access runs IDLE -> CMD (-> RWAIT for reads) -> IDLE. Reads return
// data with a one-cycle rvalid pulse. Writes that land in the read-only
// input-mirror window [RO_LO, RO_HI] are suppressed and flagged with err.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mN_req/we/addr/wdata           master N request, held until mN_gnt
//   mN_gnt                         pulse: command issued to memory
//   mN_rvalid/mN_rdata             pulse + read data (rdata held)
//   mN_err                         pulse with gnt on a blocked write
//   mem_rw_select/address/data_in  command to gpiomem (rw_select 1 = write)
//   mem_data_out                   registered read data from gpiomem
module gpio_mem_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RO_LO      = 503,
  parameter int unsigned RO_HI      = 505,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_rw_select,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, CMD, RWAIT} state_t;

  state_t state;
  logic   last_grant;   // master granted most recently (1 = m1)
  logic   cmd_master;   // owner of the in-flight command
  logic   cmd_we;

  logic              pick_m1_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              sel_blocked_c;

  // Winner selection and command mux, consumed only in IDLE.
  always_comb begin
    pick_m1_c = 1'b0;
    if (FIXED_PRIO != 0) begin
      pick_m1_c = ~m0_req;
    end else if (m0_req && m1_req) begin
      pick_m1_c = ~last_grant;
    end else begin
      pick_m1_c = m1_req;
    end
    sel_we_c      = pick_m1_c ? m1_we    : m0_we;
    sel_addr_c    = pick_m1_c ? m1_addr  : m0_addr;
    sel_wdata_c   = pick_m1_c ? m1_wdata : m0_wdata;
    sel_blocked_c = sel_we_c && (sel_addr_c >= ADDR_W'(RO_LO)) &&
                    (sel_addr_c <= ADDR_W'(RO_HI));
  end

  // Sequencer; gnt/err/rvalid/rw_select are single-cycle pulses by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      cmd_master    <= 1'b0;
      cmd_we        <= 1'b0;
      m0_gnt        <= 1'b0;
      m0_rvalid     <= 1'b0;
      m0_rdata      <= '0;
      m0_err        <= 1'b0;
      m1_gnt        <= 1'b0;
      m1_rvalid     <= 1'b0;
      m1_rdata      <= '0;
      m1_err        <= 1'b0;
      mem_rw_select <= 1'b0;
      mem_address   <= '0;
      mem_data_in   <= '0;
    end else begin
      m0_gnt        <= 1'b0;
      m1_gnt        <= 1'b0;
      m0_err        <= 1'b0;
      m1_err        <= 1'b0;
      m0_rvalid     <= 1'b0;
      m1_rvalid     <= 1'b0;
      mem_rw_select <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state         <= CMD;
            cmd_master    <= pick_m1_c;
            cmd_we        <= sel_we_c;
            last_grant    <= pick_m1_c;
            mem_address   <= sel_addr_c;
            mem_data_in   <= sel_wdata_c;
            mem_rw_select <= sel_we_c && !sel_blocked_c;
            m0_gnt        <= ~pick_m1_c;
            m1_gnt        <= pick_m1_c;
            m0_err        <= ~pick_m1_c && sel_blocked_c;
            m1_err        <= pick_m1_c && sel_blocked_c;
          end
        end
        CMD: begin
          state <= cmd_we ? IDLE : RWAIT;
        end
        RWAIT: begin
          // gpiomem registered its read at the end of CMD.
          if (cmd_master) begin
            m1_rdata  <= mem_data_out;
            m1_rvalid <= 1'b1;
          end else begin
            m0_rdata  <= mem_data_out;
            m0_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mem_arbiter.sv
// tb_gpio_mem_arbiter: directed bench for gpio_mem_arbiter with a gpiomem
// model (switch values at 503..505). A second instance with FIXED_PRIO = 1
// shares the request inputs for the priority check.
module tb_gpio_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [8:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       mem_rw_select;
  logic [8:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;

  logic       f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err;
  logic [7:0] f_m0_rdata, f_m1_rdata;
  logic       f_mem_rw_select;
  logic [8:0] f_mem_address;
  logic [7:0] f_mem_data_in;
  logic [7:0] f_mem_data_out;
  assign f_mem_data_out = 8'h00;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] mem    [0:511];
  logic [7:0] shadow [0:511];

  always #5 clk = ~clk;

  gpio_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_rw_select(mem_rw_select), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  gpio_mem_arbiter #(.FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .mem_rw_select(f_mem_rw_select), .mem_address(f_mem_address),
    .mem_data_in(f_mem_data_in), .mem_data_out(f_mem_data_out)
  );

  // gpiomem model: 1-cycle registered read; 503..505 mirror fixed switch values.
  always @(posedge clk) begin
    if (mem_rw_select) mem[mem_address] <= mem_data_in;
    case (mem_address)
      9'd503:  mem_data_out <= 8'h11;
      9'd504:  mem_data_out <= 8'h22;
      9'd505:  mem_data_out <= 8'h33;
      default: mem_data_out <= mem[mem_address];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A memory write may only appear alongside a grant that was not blocked.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_rw_select === 1'b1)
      chk("rw_only_in_cmd", {30'd0, m0_gnt | m1_gnt, m0_err | m1_err}, 32'h2);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [8:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end
  endtask

  function automatic logic in_win(input logic [8:0] a);
    return (a >= 9'd503) && (a <= 9'd505);
  endfunction

  function automatic logic [7:0] model_read(input logic [8:0] a);
    case (a)
      9'd503:  return 8'h11;
      9'd504:  return 8'h22;
      9'd505:  return 8'h33;
      default: return shadow[a];
    endcase
  endfunction

  // One access from idle: gnt at cycle 1, rvalid at cycle 3 for reads.
  task automatic xact(input int m, input logic we, input logic [8:0] a,
                      input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    logic blk;
    blk = we && in_win(a);
    drive(m, 1'b1, we, a, d);
    step;
    chk({tag, "_gnt"},   32'((m == 0) ? m0_gnt : m1_gnt), 32'd1);
    chk({tag, "_ogn"},   32'((m == 0) ? m1_gnt : m0_gnt), 32'd0);
    chk({tag, "_err"},   32'((m == 0) ? m0_err : m1_err), 32'(blk));
    chk({tag, "_rw"},    32'(mem_rw_select), 32'(we && !blk));
    chk({tag, "_addr"},  32'(mem_address), 32'(a));
    if (we && !blk) begin
      chk({tag, "_din"}, 32'(mem_data_in), 32'(d));
      shadow[a] = d;
    end
    drive(m, 1'b0, 1'b0, 9'd0, 8'd0);
    step;
    if (we) begin
      chk({tag, "_rw_off"}, 32'(mem_rw_select), 32'd0);
    end else begin
      chk({tag, "_rv_early"}, 32'((m == 0) ? m0_rvalid : m1_rvalid), 32'd0);
      step;
      chk({tag, "_rvalid"}, 32'((m == 0) ? m0_rvalid : m1_rvalid), 32'd1);
      chk({tag, "_rdata"},  32'((m == 0) ? m0_rdata : m1_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    logic [8:0] aset [8];
    logic [8:0] a;
    logic [7:0] exp_m0;
    int         m;
    logic       we;
    aset = '{9'h000, 9'h0FF, 9'd502, 9'd503, 9'd504, 9'd505, 9'd506, 9'h1FF};

    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 9'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 9'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulses", {25'd0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_rw_select}, 32'd0);
    chk("rst_mem", {15'd0, mem_address, mem_data_in}, 32'd0);
    chk("rst_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);
    rst_n = 1'b1;

    // Basic write then read-back.
    xact(0, 1'b1, 9'h1FA, 8'hA5, 8'h00, "t1_wr");
    xact(0, 1'b0, 9'h1FA, 8'h00, 8'hA5, "t1_rd");

    // Protected window and its edges.
    xact(1, 1'b1, 9'd504, 8'h3C, 8'h00, "ro_wr504");
    xact(1, 1'b0, 9'd504, 8'h00, 8'h22, "ro_rd504");
    xact(0, 1'b1, 9'd502, 8'h5A, 8'h00, "edge_wr502");
    xact(0, 1'b1, 9'd506, 8'h6B, 8'h00, "edge_wr506");
    xact(0, 1'b1, 9'd503, 8'h77, 8'h00, "ro_wr503");
    xact(0, 1'b1, 9'd505, 8'h88, 8'h00, "ro_wr505");
    xact(0, 1'b0, 9'd502, 8'h00, 8'h5A, "edge_rd502");
    xact(0, 1'b0, 9'd503, 8'h00, 8'h11, "ro_rd503");
    xact(1, 1'b0, 9'd505, 8'h00, 8'h33, "ro_rd505");
    xact(1, 1'b0, 9'd506, 8'h00, 8'h6B, "edge_rd506");

    // Random mix over a small address set, checked against the shadow copy.
    for (int i = 0; i < 8; i++)
      xact(i % 2, 1'b1, aset[i], 8'($urandom), 8'h00, "rnd_init");
    for (int i = 0; i < 24; i++) begin
      m  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = aset[$urandom_range(0, 7)];
      xact(m, we, a, 8'($urandom), model_read(a), "rnd");
    end

    // Reset while an m1 read sits in RWAIT.
    drive(1, 1'b1, 1'b0, 9'h1FA, 8'h00);
    step;
    chk("rstmid_gnt", 32'(m1_gnt), 32'd1);
    drive(1, 1'b0, 1'b0, 9'd0, 8'd0);
    step;
    rst_n = 1'b0;
    #1;
    chk("rstmid_pulses", {25'd0, m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_rw_select}, 32'd0);
    chk("rstmid_mem", {15'd0, mem_address, mem_data_in}, 32'd0);
    chk("rstmid_rdata", {16'd0, m0_rdata, m1_rdata}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("rstmid_no_rvalid", 32'(m1_rvalid), 32'd0);
    end

    // Contested continuous reads: m0 first after reset, then alternate.
    exp_m0 = model_read(9'h1FA);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 9'h1FA, 8'h00);
    drive(1, 1'b1, 1'b0, 9'd504, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      step;
      chk("rr_m0_gnt", 32'(m0_gnt), 32'((c % 3 == 1) && ((c / 3) % 2 == 0)));
      chk("rr_m1_gnt", 32'(m1_gnt), 32'((c % 3 == 1) && ((c / 3) % 2 == 1)));
      chk("rr_m0_rvalid", 32'(m0_rvalid), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
      chk("rr_m1_rvalid", 32'(m1_rvalid), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
      if (c == 3) chk("rr_m0_rdata", 32'(m0_rdata), 32'(exp_m0));
      if (c == 6) chk("rr_m1_rdata", 32'(m1_rdata), 32'h22);
      chk("fp_m0_gnt", 32'(f_m0_gnt), 32'(c % 3 == 1));
      chk("fp_m1_gnt", 32'(f_m1_gnt), 32'd0);
    end
    drive(0, 1'b0, 1'b0, 9'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 9'd0, 8'd0);
    repeat (4) step;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gpio_mem_arbiter.md
Name: gpio_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port gpiomem (9-bit address, 8-bit data, rw_select, 1-cycle registered read) between master 0 (CPU load/store unit) and master 1 (peripheral refresher/debug port).
- Sequences every access as a fixed command/wait cycle and returns read data with a valid pulse.
- Blocks writes to the read-only input-mirror window (buttons/switches, 503–505) and flags them.

Parameters:
ADDR_W, 9, memory address width
DATA_W, 8, memory data width
RO_LO, 503, lowest write-protected address (inclusive)
RO_HI, 505, highest write-protected address (inclusive)
FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  one-cycle pulse: command issued to memory this cycle
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
m0_rdata  out  DATA_W  read data, held until next m0 read completes
m0_err  out  1  one-cycle pulse, coincident with m0_gnt, on a blocked write
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  —  identical to m0_*
mem_rw_select  out  1  to gpiomem rw_select (1 = write)
mem_address  out  ADDR_W  to gpiomem address
mem_data_in  out  DATA_W  to gpiomem data_in
mem_data_out  in  DATA_W  from gpiomem data_out

Behaviour:
- All outputs registered. On reset:
  - FSM = IDLE; mem_rw_select = 0; mem_address = 0; mem_data_in = 0.
  - All gnt/rvalid/err = 0; m0_rdata = m1_rdata = 0.
  - last_grant = 1, so master 0 wins the first contested arbitration.
- FSM states: IDLE, CMD, RWAIT.
- IDLE:
  - No req: stay; mem_rw_select = 0.
  - Any req: pick a winner.
    - Round-robin: if both request, take the master not equal to last_grant; otherwise take the sole requester.
    - FIXED_PRIO = 1: master 0 wins whenever it requests.
  - Latch the winner's we/addr/wdata into the command registers; update last_grant; go to CMD.
- CMD (exactly 1 cycle):
  - mem_address and mem_data_in driven from the command registers.
  - mem_rw_select = we AND NOT (RO_LO ≤ addr ≤ RO_HI).
  - Winner's gnt = 1.
  - Protected write: err = 1 with gnt; memory is not written (mem_rw_select = 0).
  - Write (including blocked): go to IDLE. Read: go to RWAIT.
- RWAIT (1 cycle):
  - mem_rw_select = 0; mem_address held.
  - mem_data_out (registered by gpiomem at end of CMD) is captured into the winner's rdata.
  - Winner's rvalid pulses in the following cycle; go to IDLE.
- Timing (req first seen in IDLE at cycle 0):
  - gnt at cycle 1.
  - Write committed at the cycle 1→2 edge.
  - Read rvalid/rdata at cycle 3.
- Throughput:
  - Back-to-back writes: 1 per 2 cycles. Reads: 1 per 3 cycles.
  - An IDLE cycle always separates transactions; arbitration happens only in IDLE.
- mem_rw_select is 1 only in CMD for an unblocked write. No spurious writes in any other state or during reset.
- A requester deasserting req before gnt is a protocol violation. The latched command still completes; no check is required.
- Blocked read: none — reads of 503–505 are always permitted.
- The rvalid pulse of a read may coincide with the next IDLE arbitration. Both proceed independently.
- Reset asserted mid-CMD or mid-RWAIT:
  - Immediate return to reset values; the in-flight read is dropped with no rvalid.
  - mem_rw_select drops to 0 asynchronously.
- last_grant updates only on a grant, never on idle cycles.

Test Plan:
- Reset, then m0 write addr 0x1FA data 0xA5 → m0_gnt at cycle 1 with mem_rw_select = 1, mem_address = 0x1FA, mem_data_in = 0xA5; m0 read 0x1FA → m0_rvalid at cycle 3, m0_rdata = 0xA5.
- m0 and m1 both hold read requests continuously (round-robin) → grants alternate m0, m1, m0, m1 with one grant per 3 cycles; after reset m0 is granted first. Same stimulus with FIXED_PRIO = 1 → m1 never granted while m0_req is held.
- m1 writes 0x3C to 504 → m1_gnt and m1_err both pulse, mem_rw_select stays 0; a subsequent m1 read of 504 returns the switches value, not 0x3C.
- m0 write to 502 and 506 (edges of window) → no err, mem_rw_select = 1; writes to 503 and 505 → err = 1, no write.
- Assert rst_n = 0 during RWAIT of an m1 read → m1_rvalid never pulses, all outputs zero; after release, m0 wins the first contested request.
- Random interleaved reads/writes from both masters against a gpiomem model → every read returns the last unblocked write to that address; mem_rw_select never high outside CMD.
